// File: rtl/cmd_sequencer_if.sv
// Command/response link between cmd_sequencer (master) and RemoteComm (slave).
interface cmd_sequencer_if #(
   parameter int CMD_W  = 16,
   parameter int RESP_W = 8
);
   // send_cmd is a one-cycle strobe qualifying cmd; cmd stays stable until the next strobe.
   // resp is valid while resp_rdy is high; each rising edge of resp_rdy is one response.
   logic              send_cmd;
   logic [CMD_W-1:0]  cmd;
   logic              resp_rdy;
   logic [RESP_W-1:0] resp;

   modport master (output send_cmd, cmd, input resp_rdy, resp);
   modport slave  (input send_cmd, cmd, output resp_rdy, resp);
endinterface

// File: rtl/cmd_sequencer.sv
// Scripted command player: plays a loaded command table over the RemoteComm link,
// checks each response against ACK and reports pass/fail with the failing index.
module cmd_sequencer #(
   parameter int                DEPTH     = 8,
   parameter int                CMD_W     = 16,
   parameter int                RESP_W    = 8,
   parameter logic [RESP_W-1:0] ACK       = 'hA5,
   parameter int                TIMEOUT_W = 24,
   parameter int                GAP_CYC   = 2,
   localparam int               IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int               NW        = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load_en,
   input  logic [IW-1:0]        load_addr,
   input  logic [CMD_W-1:0]     load_cmd,
   input  logic [NW-1:0]        num_cmds,
   input  logic                 start,
   input  logic                 abort,
   cmd_sequencer_if.master      link,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic                 fail,
   output logic [1:0]           err_code,
   output logic [IW-1:0]        cmd_idx,
   output logic [2:0]           dbg_state
);
   localparam int GW = $clog2(GAP_CYC + 1);
   localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'((2 ** TIMEOUT_W) - 2);
   localparam logic [1:0] ERR_NONE = 2'b00, ERR_NAK = 2'b01, ERR_TMO = 2'b10, ERR_ABORT = 2'b11;

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [CMD_W-1:0]     table_q [DEPTH];
   logic [CMD_W-1:0]     cmd_q, cmd_d;
   logic                 send_q, send_d, busy_q, busy_d, done_q, done_d;
   logic                 pass_q, pass_d, fail_q, fail_d, rdy_q, rdy_d;
   logic [1:0]           err_q, err_d;
   logic [IW-1:0]        idx_q, idx_d, idx_inc;
   logic [NW-1:0]        num_q, num_d, num_sat;
   logic [TIMEOUT_W-1:0] to_q, to_d;
   logic [GW-1:0]        gap_q, gap_d;
   logic                 more_cmds, resp_edge;

   always_ff @(posedge clk) begin
      if (load_en && !busy_q) table_q[load_addr] <= load_cmd;
   end

   assign num_sat   = (num_cmds > NW'(DEPTH)) ? NW'(DEPTH) : num_cmds;
   assign idx_inc   = idx_q + IW'(1);
   assign more_cmds = (NW'(idx_q) + NW'(1)) < num_q;
   // rdy_q is cleared in ISSUE so a level still high from the previous response counts as new.
   assign resp_edge = link.resp_rdy && !rdy_q;

   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      send_d  = 1'b0;
      done_d  = done_q;
      pass_d  = pass_q;
      fail_d  = fail_q;
      err_d   = err_q;
      idx_d   = idx_q;
      num_d   = num_q;
      to_d    = to_q;
      gap_d   = gap_q;
      rdy_d   = link.resp_rdy;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start && !abort) begin
               done_d = 1'b0;
               pass_d = 1'b0;
               fail_d = 1'b0;
               err_d  = ERR_NONE;
               idx_d  = '0;
               num_d  = num_sat;
               if (num_sat == '0) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  pass_d  = 1'b1;
               end else begin
                  state_d = S_ISSUE;
                  send_d  = 1'b1;
                  cmd_d   = table_q[0];
               end
            end
         end
         S_ISSUE: begin
            rdy_d   = 1'b0;
            to_d    = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (resp_edge) begin
               if (link.resp == ACK) begin
                  state_d = S_GAP;
                  gap_d   = '0;
               end else begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  fail_d  = 1'b1;
                  err_d   = ERR_NAK;
               end
            end else if (to_q == TO_LAST) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               fail_d  = 1'b1;
               err_d   = ERR_TMO;
            end else begin
               to_d = to_q + 1'b1;
            end
         end
         S_GAP: begin
            if (gap_q == GW'(GAP_CYC - 1)) begin
               if (more_cmds) begin
                  state_d = S_ISSUE;
                  idx_d   = idx_inc;
                  send_d  = 1'b1;
                  cmd_d   = table_q[idx_inc];
               end else begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  pass_d  = 1'b1;
               end
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Abort overrides whatever the active state decided; index stays frozen.
      if (abort && busy_q) begin
         state_d = S_DONE;
         send_d  = 1'b0;
         cmd_d   = cmd_q;
         done_d  = 1'b1;
         pass_d  = 1'b0;
         fail_d  = 1'b1;
         err_d   = ERR_ABORT;
         idx_d   = idx_q;
      end
      busy_d = (state_d == S_ISSUE) || (state_d == S_WAIT) || (state_d == S_GAP);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cmd_q   <= '0;
         send_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         fail_q  <= 1'b0;
         err_q   <= ERR_NONE;
         idx_q   <= '0;
         num_q   <= '0;
         to_q    <= '0;
         gap_q   <= '0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         send_q  <= send_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         fail_q  <= fail_d;
         err_q   <= err_d;
         idx_q   <= idx_d;
         num_q   <= num_d;
         to_q    <= to_d;
         gap_q   <= gap_d;
         rdy_q   <= rdy_d;
      end
   end

   assign link.send_cmd = send_q;
   assign link.cmd      = cmd_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign pass          = pass_q;
   assign fail          = fail_q;
   assign err_code      = err_q;
   assign cmd_idx       = idx_q;
   assign dbg_state     = state_q;
endmodule

// File: tb/tb_cmd_sequencer.sv
// Randomized bench for cmd_sequencer: a scripted RemoteComm responder plus a
// table-walking reference model of the expected command stream and verdict.
module tb_cmd_sequencer;
   localparam int         DEPTH     = 8;
   localparam int         CMD_W     = 16;
   localparam int         RESP_W    = 8;
   localparam int         TIMEOUT_W = 6;
   localparam int         GAP_CYC   = 2;
   localparam logic [7:0] ACK_V     = 8'hA5;
   localparam int         NO_POS    = 99;
   localparam int         BOUND     = 300;

   logic             clk = 1'b0, rst_n = 1'b0;
   logic             load_en = 1'b0, start = 1'b0, abort = 1'b0;
   logic [2:0]       load_addr = '0;
   logic [15:0]      load_cmd = '0;
   logic [3:0]       num_cmds = '0;
   logic             busy, done, pass, fail;
   logic [1:0]       err_code;
   logic [2:0]       cmd_idx, dbg_state;

   cmd_sequencer_if #(.CMD_W(CMD_W), .RESP_W(RESP_W)) link ();

   cmd_sequencer #(.DEPTH(DEPTH), .CMD_W(CMD_W), .RESP_W(RESP_W), .ACK(ACK_V),
                   .TIMEOUT_W(TIMEOUT_W), .GAP_CYC(GAP_CYC)) dut (
      .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
      .load_cmd(load_cmd), .num_cmds(num_cmds), .start(start), .abort(abort),
      .link(link), .busy(busy), .done(done), .pass(pass), .fail(fail),
      .err_code(err_code), .cmd_idx(cmd_idx), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   logic [CMD_W-1:0] tbl [DEPTH];
   logic [CMD_W-1:0] exp_q [$];
   logic [CMD_W-1:0] sent_q [$];
   int n_checks = 0, n_fail = 0;
   int last_send_cyc = 0, wait_cnt = 0, resp_pos = 0;
   int nak_pos = NO_POS, silent_pos = NO_POS;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- RemoteComm responder ----------------
   initial begin
      link.resp_rdy = 1'b0;
      link.resp     = '0;
      forever begin
         @(negedge clk);
         link.resp_rdy = 1'b0;
         link.resp     = 8'($urandom);
         if (!rst_n) begin
            wait_cnt = 0;
         end else if (link.send_cmd) begin
            sent_q.push_back(link.cmd);
            last_send_cyc = cyc;
            resp_pos = sent_q.size() - 1;
            wait_cnt = (resp_pos >= silent_pos && resp_pos != nak_pos) ? 0 : int'($urandom_range(1, 5));
         end else if (wait_cnt > 0) begin
            wait_cnt--;
            if (wait_cnt == 0) begin
               link.resp_rdy = 1'b1;
               link.resp     = (resp_pos == nak_pos) ? 8'h5A : ACK_V;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic load_entry(input int addr, input logic [CMD_W-1:0] data);
      @(negedge clk);
      load_en = 1'b1; load_addr = 3'(addr); load_cmd = data;
      @(negedge clk);
      load_en = 1'b0;
      tbl[addr] = data;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, ".send"}, link.send_cmd, 0);
      check({tag, ".cmd"}, link.cmd, 0);
      check({tag, ".busy"}, busy, 0);
      check({tag, ".done"}, done, 0);
      check({tag, ".pass"}, pass, 0);
      check({tag, ".fail"}, fail, 0);
      check({tag, ".err"}, err_code, 0);
      check({tag, ".idx"}, cmd_idx, 0);
      check({tag, ".state"}, dbg_state, 0);
   endtask

   // Plays one sequence; nak/silent pick which entry gets a NAK or no reply,
   // abort_after >= 0 aborts that many cycles into the silent entry's wait.
   task automatic run_seq(input string tag, input int num, input int nak, input int silent,
                          input int abort_after, input bit poke);
      int n, exp_sent, exp_err, exp_idx, t0, ab_cnt, n_sent;
      bit poked;
      n = (num > DEPTH) ? DEPTH : num;
      exp_sent = n; exp_err = 0; exp_idx = (n > 0) ? n - 1 : 0;
      for (int i = 0; i < n; i++) begin
         if (i == nak) begin exp_err = 1; exp_idx = i; exp_sent = i + 1; break; end
         if (i >= silent) begin
            exp_err = (abort_after >= 0) ? 3 : 2; exp_idx = i; exp_sent = i + 1; break;
         end
      end
      exp_q.delete();
      for (int i = 0; i < exp_sent; i++) exp_q.push_back(tbl[i]);
      nak_pos = nak; silent_pos = silent;
      sent_q.delete();

      @(negedge clk);
      num_cmds = 4'(num); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, ".send_lat"}, link.send_cmd, (n > 0) ? 1 : 0);

      t0 = 0; ab_cnt = abort_after; poked = 1'b0;
      while (!done && t0 < BOUND) begin
         abort = 1'b0;
         if (ab_cnt >= 0 && sent_q.size() == silent + 1) begin
            if (ab_cnt == 0) abort = 1'b1;
            ab_cnt--;
         end
         if (poke && busy && !poked) begin
            load_en = 1'b1; load_addr = 3'd1; load_cmd = ~tbl[1]; start = 1'b1; poked = 1'b1;
         end else begin
            load_en = 1'b0; start = 1'b0;
         end
         @(negedge clk);
         t0++;
      end
      abort = 1'b0; load_en = 1'b0; start = 1'b0;

      check({tag, ".bound"}, t0 < BOUND, 1);
      check({tag, ".done"}, done, 1);
      check({tag, ".busy"}, busy, 0);
      check({tag, ".pass"}, pass, (exp_err == 0) ? 1 : 0);
      check({tag, ".fail"}, fail, (exp_err != 0) ? 1 : 0);
      check({tag, ".err"}, err_code, exp_err);
      check({tag, ".idx"}, cmd_idx, exp_idx);
      if (exp_err == 2) check({tag, ".tmo_cyc"}, cyc - last_send_cyc, 64);

      @(negedge clk);
      check({tag, ".sticky"}, done, 1);
      n_sent = sent_q.size();
      check({tag, ".n_sent"}, n_sent, exp_sent);
      while (exp_q.size() > 0 && sent_q.size() > 0)
         check({tag, ".cmd"}, sent_q.pop_front(), exp_q.pop_front());
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int num, nak, silent, ab;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      rst_n = 1'b1;

      load_entry(0, 16'h0000);
      load_entry(1, 16'h23FF);
      load_entry(2, 16'h2000);
      load_entry(3, 16'h4002);
      load_entry(4, 16'h6000);
      for (int i = 5; i < DEPTH; i++) load_entry(i, 16'($urandom));

      run_seq("ack5",   5,  NO_POS, NO_POS, -1, 1'b0);
      run_seq("nak2",   5,  2,      NO_POS, -1, 1'b0);
      run_seq("tmo0",   5,  NO_POS, 0,      -1, 1'b0);
      run_seq("abort1", 5,  NO_POS, 1,      3,  1'b0);
      run_seq("zero",   0,  NO_POS, NO_POS, -1, 1'b0);
      run_seq("sat",    12, NO_POS, NO_POS, -1, 1'b0);
      run_seq("poke",   8,  NO_POS, 2,      4,  1'b1);
      run_seq("after_poke", 8, NO_POS, NO_POS, -1, 1'b0);

      // start and abort together while DONE: both ignored
      @(negedge clk);
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      check("st_ab.done", done, 1);
      check("st_ab.busy", busy, 0);
      check("st_ab.send", link.send_cmd, 0);
      check("st_ab.pass", pass, 1);

      // reset in the middle of a response wait
      nak_pos = NO_POS; silent_pos = 0;
      @(negedge clk);
      num_cmds = 4'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      check("mid.busy", busy, 1);
      rst_n = 1'b0;
      @(negedge clk);
      check_outputs_zero("mid_rst");
      rst_n = 1'b1;

      for (int r = 0; r < 12; r++) begin
         load_entry(int'($urandom_range(0, DEPTH - 1)), 16'($urandom));
         num = int'($urandom_range(0, 12));
         nak = ($urandom_range(0, 2) == 0) ? NO_POS : int'($urandom_range(0, 9));
         silent = NO_POS; ab = -1;
         if ($urandom_range(0, 3) == 0) begin
            silent = int'($urandom_range(0, 7));
            nak = NO_POS;
            if ($urandom_range(0, 1) == 1) ab = int'($urandom_range(1, 10));
         end
         run_seq($sformatf("rand%0d", r), num, nak, silent, ab, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
